// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared CP0 TLB definitions: register numbers, the 86-bit
//                TLB entry image layout and EntryLo/EntryHi field offsets.
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

   // CP0 register numbers handled by the TLB register slice
   localparam logic [4:0] c_reg_index    = 5'd0;
   localparam logic [4:0] c_reg_random   = 5'd1;
   localparam logic [4:0] c_reg_entrylo0 = 5'd2;
   localparam logic [4:0] c_reg_entrylo1 = 5'd3;
   localparam logic [4:0] c_reg_context  = 5'd4;
   localparam logic [4:0] c_reg_pagemask = 5'd5;
   localparam logic [4:0] c_reg_wired    = 5'd6;
   localparam logic [4:0] c_reg_badvaddr = 5'd8;
   localparam logic [4:0] c_reg_entryhi  = 5'd10;
   localparam logic [4:0] c_reg_config   = 5'd16;

   // EntryLo field offsets (stored image is the low 26 bits of the register)
   localparam int c_elo_g_bit    = 0;
   localparam int c_elo_v_bit    = 1;
   localparam int c_elo_d_bit    = 2;
   localparam int c_elo_c_lsb    = 3;
   localparam int c_elo_pfn_lsb  = 6;
   localparam int c_elo_w        = 26;

   // EntryHi field offsets
   localparam int c_ehi_asid_lsb = 0;
   localparam int c_ehi_vpn2_lsb = 13;

   // Entry image exchanged with the translation block
   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
      logic [7:0]  rsvd;
   } tlb_entry_t;

endpackage
`default_nettype wire

// File: rtl/cp0_random_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_random_ctr
//  Description : Random register: free-running down-counter that wraps from
//                Wired back to the top entry and reloads on any Wired write.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_random_ctr #(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wired_we,
   input  logic [IDX_W-1:0] wired,
   output logic [IDX_W-1:0] random
);

   localparam logic [IDX_W-1:0] c_top = '1;
   localparam logic [IDX_W-1:0] c_one = IDX_W'(1);

   logic [IDX_W-1:0] r_random;

   // Count down every cycle; hitting the Wired floor or a Wired write reloads the top
   always_ff @(posedge clk) begin
      if (rst || wired_we) begin
         r_random <= c_top;
      end else if (r_random == wired) begin
         r_random <= c_top;
      end else begin
         r_random <= r_random - c_one;
      end
   end

   assign random = r_random;

endmodule
`default_nettype wire

// File: rtl/cp0_tlb_regs.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_tlb_regs
//  Description : CP0 registers owning MMU-visible TLB state (Index, Random,
//                EntryLo0/1, Context, PageMask, Wired, BadVAddr, EntryHi,
//                Config.K0). Feeds the translation block and absorbs its
//                TLBR/TLBP results and TLB exception information.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_tlb_regs
   import cp0_pkg::*;
#(
   parameter int         TLB_IDX_W = 4,
   parameter logic [2:0] K0_RESET  = 3'b011
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 reg_we,
   input  logic [4:0]           reg_waddr,
   input  logic [31:0]          reg_wdata,
   input  logic [4:0]           reg_raddr,
   output logic [31:0]          reg_rdata,
   input  logic                 tlbr,
   input  logic                 tlbp,
   input  logic                 exc_tlb,
   input  logic [31:0]          exc_vaddr,
   input  logic                 miss_probe,
   input  logic [TLB_IDX_W-1:0] matched_index_probe,
   input  logic [85:0]          cp0_tlb_conf_out,
   output logic [85:0]          cp0_tlb_conf_in,
   output logic [TLB_IDX_W-1:0] cp0_index,
   output logic [TLB_IDX_W-1:0] cp0_random,
   output logic [7:0]           curr_ASID,
   output logic                 cp0_kseg0_uncached
);

   logic                   r_index_p;
   logic [TLB_IDX_W-1:0]   r_index;
   logic [c_elo_w-1:0]     r_lo0;
   logic [c_elo_w-1:0]     r_lo1;
   logic [8:0]             r_pte_base;
   logic [18:0]            r_bad_vpn2;
   logic [TLB_IDX_W-1:0]   r_wired;
   logic [31:0]            r_badvaddr;
   logic [18:0]            r_vpn2;
   logic [7:0]             r_asid;
   logic [2:0]             r_k0;
   logic [TLB_IDX_W-1:0]   w_random;
   tlb_entry_t             w_conf_out;
   tlb_entry_t             w_conf_in;

   logic w_wr_index, w_wr_lo0, w_wr_lo1, w_wr_ctx, w_wr_wired, w_wr_ehi, w_wr_cfg;

   assign w_wr_index = reg_we && (reg_waddr == c_reg_index);
   assign w_wr_lo0   = reg_we && (reg_waddr == c_reg_entrylo0);
   assign w_wr_lo1   = reg_we && (reg_waddr == c_reg_entrylo1);
   assign w_wr_ctx   = reg_we && (reg_waddr == c_reg_context);
   assign w_wr_wired = reg_we && (reg_waddr == c_reg_wired);
   assign w_wr_ehi   = reg_we && (reg_waddr == c_reg_entryhi);
   assign w_wr_cfg   = reg_we && (reg_waddr == c_reg_config);

   assign w_conf_out = cp0_tlb_conf_out;

   // Bits that carry no state in this slice
   logic w_unused;
   assign w_unused = ^{reg_wdata[12:8], w_conf_out.rsvd};

   cp0_random_ctr #(.IDX_W(TLB_IDX_W)) u_random (
      .clk      (clk),
      .rst      (rst),
      .wired_we (w_wr_wired),
      .wired    (r_wired),
      .random   (w_random)
   );

   // Index: probe result outranks software writes; P is only set by hardware
   always_ff @(posedge clk) begin
      if (rst) begin
         r_index_p <= 1'b0;
         r_index   <= '0;
      end else if (tlbp) begin
         r_index_p <= miss_probe;
         if (!miss_probe) r_index <= matched_index_probe;
      end else if (w_wr_index) begin
         r_index <= reg_wdata[TLB_IDX_W-1:0];
      end
   end

   // EntryLo0/1: TLBR reload outranks software writes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lo0 <= '0;
         r_lo1 <= '0;
      end else if (tlbr) begin
         r_lo0 <= {w_conf_out.pfn0, w_conf_out.c0, w_conf_out.d0, w_conf_out.v0, w_conf_out.g};
         r_lo1 <= {w_conf_out.pfn1, w_conf_out.c1, w_conf_out.d1, w_conf_out.v1, w_conf_out.g};
      end else begin
         if (w_wr_lo0) r_lo0 <= reg_wdata[c_elo_w-1:0];
         if (w_wr_lo1) r_lo1 <= reg_wdata[c_elo_w-1:0];
      end
   end

   // Context and BadVAddr: an exception claims the whole register for that cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pte_base <= '0;
         r_bad_vpn2 <= '0;
         r_badvaddr <= '0;
      end else if (exc_tlb) begin
         r_bad_vpn2 <= exc_vaddr[31:13];
         r_badvaddr <= exc_vaddr;
      end else if (w_wr_ctx) begin
         r_pte_base <= reg_wdata[31:23];
      end
   end

   // EntryHi: exception keeps the ASID, TLBR reloads both fields
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vpn2 <= '0;
         r_asid <= '0;
      end else if (exc_tlb) begin
         r_vpn2 <= exc_vaddr[31:13];
      end else if (tlbr) begin
         r_vpn2 <= w_conf_out.vpn2;
         r_asid <= w_conf_out.asid;
      end else if (w_wr_ehi) begin
         r_vpn2 <= reg_wdata[c_ehi_vpn2_lsb +: 19];
         r_asid <= reg_wdata[c_ehi_asid_lsb +: 8];
      end
   end

   // Wired and Config.K0 are software-only
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wired <= '0;
         r_k0    <= K0_RESET;
      end else begin
         if (w_wr_wired) r_wired <= reg_wdata[TLB_IDX_W-1:0];
         if (w_wr_cfg)   r_k0    <= reg_wdata[2:0];
      end
   end

   // Entry image presented to the translation block for TLBWI/TLBWR
   always_comb begin
      w_conf_in      = '0;
      w_conf_in.vpn2 = r_vpn2;
      w_conf_in.asid = r_asid;
      w_conf_in.g    = r_lo0[c_elo_g_bit] & r_lo1[c_elo_g_bit];
      w_conf_in.pfn0 = r_lo0[c_elo_pfn_lsb +: 20];
      w_conf_in.c0   = r_lo0[c_elo_c_lsb +: 3];
      w_conf_in.d0   = r_lo0[c_elo_d_bit];
      w_conf_in.v0   = r_lo0[c_elo_v_bit];
      w_conf_in.pfn1 = r_lo1[c_elo_pfn_lsb +: 20];
      w_conf_in.c1   = r_lo1[c_elo_c_lsb +: 3];
      w_conf_in.d1   = r_lo1[c_elo_d_bit];
      w_conf_in.v1   = r_lo1[c_elo_v_bit];
      w_conf_in.rsvd = '0;
   end

   assign cp0_tlb_conf_in    = w_conf_in;
   assign cp0_index          = r_index;
   assign cp0_random         = w_random;
   assign curr_ASID          = r_asid;
   assign cp0_kseg0_uncached = (r_k0 == 3'd2);

   // MFC0 read decode; unimplemented registers and fields read as zero
   always_comb begin
      reg_rdata = '0;
      case (reg_raddr)
         c_reg_index:    reg_rdata = {r_index_p, {(31-TLB_IDX_W){1'b0}}, r_index};
         c_reg_random:   reg_rdata = {{(32-TLB_IDX_W){1'b0}}, w_random};
         c_reg_entrylo0: reg_rdata = {{(32-c_elo_w){1'b0}}, r_lo0};
         c_reg_entrylo1: reg_rdata = {{(32-c_elo_w){1'b0}}, r_lo1};
         c_reg_context:  reg_rdata = {r_pte_base, r_bad_vpn2, 4'b0};
         c_reg_pagemask: reg_rdata = '0;
         c_reg_wired:    reg_rdata = {{(32-TLB_IDX_W){1'b0}}, r_wired};
         c_reg_badvaddr: reg_rdata = r_badvaddr;
         c_reg_entryhi:  reg_rdata = {r_vpn2, 5'b0, r_asid};
         c_reg_config:   reg_rdata = {1'b1, 28'b0, r_k0};
         default:        reg_rdata = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cp0_tlb_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_tlb_regs
//  Description : Self-checking bench for cp0_tlb_regs. A word-level model of
//                the CP0 register file predicts every output and MFC0 read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_tlb_regs;

   localparam logic [2:0] c_k0_reset = 3'b011;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_we;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic [4:0]  reg_raddr;
   logic [31:0] reg_rdata;
   logic        tlbr, tlbp, exc_tlb;
   logic [31:0] exc_vaddr;
   logic        miss_probe;
   logic [3:0]  matched_index_probe;
   logic [85:0] cp0_tlb_conf_out;
   logic [85:0] cp0_tlb_conf_in;
   logic [3:0]  cp0_index, cp0_random;
   logic [7:0]  curr_ASID;
   logic        cp0_kseg0_uncached;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int rot      = 0;

   // Model: architectural read value of every CP0 register number
   logic [31:0] m [0:31];

   cp0_tlb_regs #(.TLB_IDX_W(4), .K0_RESET(c_k0_reset)) dut (
      .clk(clk), .rst(rst), .reg_we(reg_we), .reg_waddr(reg_waddr),
      .reg_wdata(reg_wdata), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
      .tlbr(tlbr), .tlbp(tlbp), .exc_tlb(exc_tlb), .exc_vaddr(exc_vaddr),
      .miss_probe(miss_probe), .matched_index_probe(matched_index_probe),
      .cp0_tlb_conf_out(cp0_tlb_conf_out), .cp0_tlb_conf_in(cp0_tlb_conf_in),
      .cp0_index(cp0_index), .cp0_random(cp0_random), .curr_ASID(curr_ASID),
      .cp0_kseg0_uncached(cp0_kseg0_uncached)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [85:0] obs, input logic [85:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Software-writable bits of each register
   function automatic logic [31:0] wmask(input logic [4:0] a);
      case (a)
         5'd0:    return 32'h0000_000F;
         5'd2:    return 32'h03FF_FFFF;
         5'd3:    return 32'h03FF_FFFF;
         5'd4:    return 32'hFF80_0000;
         5'd6:    return 32'h0000_000F;
         5'd10:   return 32'hFFFF_E0FF;
         5'd16:   return 32'h0000_0007;
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [85:0] exp_conf();
      return {m[10][31:13], m[10][7:0], m[2][0] & m[3][0], m[2][25:1], m[3][25:1], 8'h00};
   endfunction

   // Advance the model by one edge using the inputs currently applied
   task automatic model_step();
      logic [31:0] n [0:31];
      bit          t [0:31];
      for (int i = 0; i < 32; i++) begin
         n[i] = m[i];
         t[i] = 1'b0;
      end
      if (rst) begin
         for (int i = 0; i < 32; i++) n[i] = 32'h0;
         n[1]  = 32'd15;
         n[16] = 32'h8000_0000 | {29'h0, c_k0_reset};
      end else begin
         if (exc_tlb) begin
            n[8]  = exc_vaddr;
            n[10] = (exc_vaddr & 32'hFFFF_E000) | (m[10] & 32'h0000_00FF);
            n[4]  = (m[4] & 32'hFF80_0000) | ((exc_vaddr >> 13) << 4);
            t[8] = 1'b1; t[10] = 1'b1; t[4] = 1'b1;
         end
         if (tlbr) begin
            if (!t[10]) n[10] = {cp0_tlb_conf_out[85:67], 5'b0, cp0_tlb_conf_out[66:59]};
            n[2] = {6'b0, cp0_tlb_conf_out[57:33], cp0_tlb_conf_out[58]};
            n[3] = {6'b0, cp0_tlb_conf_out[32:8], cp0_tlb_conf_out[58]};
            t[10] = 1'b1; t[2] = 1'b1; t[3] = 1'b1;
         end
         if (tlbp) begin
            n[0] = miss_probe ? (32'h8000_0000 | (m[0] & 32'hF)) : {28'h0, matched_index_probe};
            t[0] = 1'b1;
         end
         if (reg_we && !t[reg_waddr])
            n[reg_waddr] = (m[reg_waddr] & ~wmask(reg_waddr)) | (reg_wdata & wmask(reg_waddr));
         if (reg_we && reg_waddr == 5'd6) n[1] = 32'd15;
         else if (m[1] == m[6])            n[1] = 32'd15;
         else                              n[1] = m[1] - 32'd1;
      end
      for (int i = 0; i < 32; i++) m[i] = n[i];
   endtask

   task automatic idle();
      rst = 1'b0; reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
      tlbr = 1'b0; tlbp = 1'b0; exc_tlb = 1'b0; exc_vaddr = '0;
      miss_probe = 1'b0; matched_index_probe = '0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      reg_raddr = a;
      #1;
      d = reg_rdata;
   endtask

   task automatic check_outputs();
      logic [31:0] d;
      logic [4:0]  a;
      int          lst [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 16};
      check("cp0_index", cp0_index, m[0][3:0]);
      check("cp0_random", cp0_random, m[1][3:0]);
      check("curr_ASID", curr_ASID, m[10][7:0]);
      check("kseg0_uncached", cp0_kseg0_uncached, m[16][2:0] == 3'd2);
      check("conf_in", cp0_tlb_conf_in, exp_conf());
      a = 5'(lst[rot % 11]);
      rot++;
      rd(a, d);
      check($sformatf("rdata[%0d]", a), d, m[a]);
      a = 5'($urandom_range(0, 31));
      rd(a, d);
      check($sformatf("rdata[%0d]", a), d, m[a]);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      idle();
      check_outputs();
   endtask

   initial begin
      logic [31:0] d;
      logic [95:0] t96;
      int          lst [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 16};
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      idle();
      reg_raddr = '0;
      cp0_tlb_conf_out = '0;
      @(negedge clk);

      // Reset
      rst = 1'b1; step();
      rst = 1'b1; step();
      check("reset_random", cp0_random, 4'd15);
      check("reset_conf_in", cp0_tlb_conf_in, 86'h0);
      rd(5'd16, d);
      check("reset_config", d, 32'h8000_0003);

      // Free-running Random with Wired = 0
      for (int k = 1; k <= 16; k++) begin
         step();
         check("rand_seq", cp0_random, (k <= 15) ? 4'(15 - k) : 4'd15);
      end

      // Wired = 12
      reg_we = 1'b1; reg_waddr = 5'd6; reg_wdata = 32'd12; step();
      check("wired_reload", cp0_random, 4'd15);
      for (int k = 1; k <= 4; k++) begin
         step();
         check("rand_wired", cp0_random, (k <= 3) ? 4'(15 - k) : 4'd15);
      end

      // Build an entry image through MTC0
      reg_we = 1'b1; reg_waddr = 5'd10; reg_wdata = 32'h0040_2005; step();
      reg_we = 1'b1; reg_waddr = 5'd2;  reg_wdata = 32'h0000_1017; step();
      reg_we = 1'b1; reg_waddr = 5'd3;  reg_wdata = 32'h0000_1016; step();
      check("conf_vpn2", cp0_tlb_conf_in[85:67], 19'h00201);
      check("conf_asid", cp0_tlb_conf_in[66:59], 8'h05);
      check("conf_g",    cp0_tlb_conf_in[58], 1'b0);
      check("conf_pfn0", cp0_tlb_conf_in[57:38], 20'h40);
      check("conf_c0",   cp0_tlb_conf_in[37:35], 3'd2);
      check("conf_dv0",  cp0_tlb_conf_in[34:33], 2'b11);

      // TLBP hit then miss
      tlbp = 1'b1; miss_probe = 1'b0; matched_index_probe = 4'd9; step();
      rd(5'd0, d);
      check("tlbp_hit", d, 32'h0000_0009);
      tlbp = 1'b1; miss_probe = 1'b1; matched_index_probe = 4'd3; step();
      rd(5'd0, d);
      check("tlbp_miss", d, 32'h8000_0009);

      // TLBR
      t96 = {$urandom(), $urandom(), $urandom()};
      cp0_tlb_conf_out = t96[85:0];
      cp0_tlb_conf_out[85:67] = 19'h7FFFF;
      cp0_tlb_conf_out[66:59] = 8'hAA;
      cp0_tlb_conf_out[58]    = 1'b1;
      tlbr = 1'b1; step();
      rd(5'd10, d);
      check("tlbr_entryhi", d, 32'hFFFF_E0AA);
      rd(5'd2, d);
      check("tlbr_lo0_g", d[0], 1'b1);
      rd(5'd3, d);
      check("tlbr_lo1_g", d[0], 1'b1);

      // TLB exception colliding with an MTC0 to EntryHi
      exc_tlb = 1'b1; exc_vaddr = 32'h1234_5678;
      reg_we = 1'b1; reg_waddr = 5'd10; reg_wdata = 32'h0;
      rd(5'd10, d);
      check("pre_edge_rdata", d, 32'hFFFF_E0AA);
      step();
      rd(5'd10, d);
      check("exc_entryhi", d, 32'h1234_40AA);
      rd(5'd8, d);
      check("exc_badvaddr", d, 32'h1234_5678);
      rd(5'd4, d);
      check("exc_context", d[22:4], 19'h091A2);

      // Config.K0 = 2
      reg_we = 1'b1; reg_waddr = 5'd16; reg_wdata = 32'h0000_0002; step();
      check("kseg0_set", cp0_kseg0_uncached, 1'b1);

      // Reset mid-stream with competing events
      rst = 1'b1; tlbp = 1'b1; matched_index_probe = 4'd7;
      reg_we = 1'b1; reg_waddr = 5'd6; reg_wdata = 32'd5; step();
      check("rst_index", cp0_index, 4'd0);
      check("rst_random", cp0_random, 4'd15);
      check("rst_asid", curr_ASID, 8'h00);
      check("rst_conf_in", cp0_tlb_conf_in, 86'h0);
      check("rst_kseg0", cp0_kseg0_uncached, 1'b0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         reg_we    = ($urandom_range(0, 2) == 0);
         reg_waddr = 5'(lst[$urandom_range(0, 10)]);
         reg_wdata = $urandom();
         tlbr      = ($urandom_range(0, 6) == 0);
         tlbp      = ($urandom_range(0, 5) == 0);
         exc_tlb   = ($urandom_range(0, 7) == 0);
         exc_vaddr = $urandom();
         miss_probe          = $urandom_range(0, 1) == 1;
         matched_index_probe = 4'($urandom());
         t96 = {$urandom(), $urandom(), $urandom()};
         cp0_tlb_conf_out = t96[85:0];
         rst = ($urandom_range(0, 79) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
